// File: rtl/cache_nway_ctrl_if.sv
// Processor-side (memreq/memresp) and memory-side (cache_req/cache_resp) handshakes
// of the N-way cache controller; master is the controller's view.
interface cache_nway_ctrl_if;
   logic memreq_val;
   logic memreq_rdy;
   logic memreq_type;
   logic memresp_val;
   logic memresp_rdy;
   logic cache_req_val;
   logic cache_req_rdy;
   logic cache_req_type;
   logic cache_resp_val;
   logic cache_resp_rdy;

   modport master (
      input  memreq_val, memreq_type, memresp_rdy, cache_req_rdy, cache_resp_val,
      output memreq_rdy, memresp_val, cache_req_val, cache_req_type, cache_resp_rdy
   );

   modport slave (
      output memreq_val, memreq_type, memresp_rdy, cache_req_rdy, cache_resp_val,
      input  memreq_rdy, memresp_val, cache_req_val, cache_req_type, cache_resp_rdy
   );
endinterface

// File: rtl/cache_nway_ctrl.sv
// Write-back, write-allocate, N-way set-associative blocking cache controller.
// Define CACHE_FLUSH_EN to build the dirty-line flush engine.
module cache_nway_ctrl #(
   parameter int unsigned NUM_WAYS       = 4,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned NUM_SETS       = 16,
   parameter int unsigned WAY_BITS       = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
   parameter int unsigned WORD_BITS      = $clog2(WORDS_PER_LINE),
   parameter int unsigned SET_BITS       = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   cache_nway_ctrl_if.master    bus,
   output logic                 reg_en_M0,
   input  logic [NUM_WAYS-1:0]  tag_match_vec,
   input  logic [NUM_WAYS-1:0]  line_valid_vec,
   input  logic [NUM_WAYS-1:0]  line_dirty_vec,
   output logic [WAY_BITS-1:0]  way_sel,
   output logic [NUM_WAYS-1:0]  tarray_wen,
   output logic [NUM_WAYS-1:0]  darray_wen,
   output logic                 darray_wsrc,
   output logic [WORD_BITS-1:0] word_idx,
   output logic [WORD_BITS-1:0] resp_word_idx,
   output logic [1:0]           addr_src,
   output logic                 dirty_set,
   output logic                 dirty_clr,
   input  logic                 flush,
   output logic                 flush_done,
   output logic [SET_BITS-1:0]  flush_set_idx
);

   typedef enum logic [2:0] {
      IDLE,
      TAG,
      SPILL,
      REFILL,
      RESP
`ifdef CACHE_FLUSH_EN
      ,
      FLUSH_RD,
      FLUSH_CHK
`endif
   } state_t;

   localparam logic [WORD_BITS-1:0] WORD_LAST = WORD_BITS'(WORDS_PER_LINE - 1);
   localparam logic [WAY_BITS-1:0]  WAY_LAST  = WAY_BITS'(NUM_WAYS - 1);

   state_t               state;
   logic                 out_en;
   logic                 type_q;
   logic                 req_done;
   logic [WAY_BITS-1:0]  way_q;
   logic [WAY_BITS-1:0]  rr_ptr;
   logic [WORD_BITS-1:0] word_q;
   logic [WORD_BITS-1:0] rword_q;
   logic                 hit;
   logic                 inv_found;
   logic [WAY_BITS-1:0]  hit_way;
   logic [WAY_BITS-1:0]  inv_way;
   logic [WAY_BITS-1:0]  victim;
   logic                 flush_go;

`ifdef CACHE_FLUSH_EN
   localparam logic [SET_BITS-1:0] SET_LAST = SET_BITS'(NUM_SETS - 1);
   logic                flushing;
   logic [SET_BITS-1:0] set_q;
   logic                dirty_found;
   logic [WAY_BITS-1:0] dirty_way;

   assign flush_go      = out_en && flush;
   assign flush_set_idx = set_q;

   always_comb begin
      dirty_found = 1'b0;
      dirty_way   = '0;
      for (int unsigned i = 0; i < NUM_WAYS; i++) begin
         if (line_valid_vec[i] && line_dirty_vec[i] && !dirty_found) begin
            dirty_found = 1'b1;
            dirty_way   = WAY_BITS'(i);
         end
      end
   end
`else
   logic unused_flush;
   assign unused_flush  = flush;
   assign flush_go      = 1'b0;
   assign flush_done    = 1'b0;
   assign flush_set_idx = '0;
`endif

   // Lowest hitting way and lowest invalid way; victim falls back to round-robin.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int unsigned i = 0; i < NUM_WAYS; i++) begin
         if (tag_match_vec[i] && !hit) begin
            hit     = 1'b1;
            hit_way = WAY_BITS'(i);
         end
         if (!line_valid_vec[i] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_BITS'(i);
         end
      end
      victim = inv_found ? inv_way : rr_ptr;
   end

   always_comb begin
      bus.memreq_rdy     = 1'b0;
      bus.memresp_val    = 1'b0;
      bus.cache_req_val  = 1'b0;
      bus.cache_req_type = 1'b0;
      bus.cache_resp_rdy = 1'b0;
      reg_en_M0          = 1'b0;
      way_sel            = way_q;
      tarray_wen         = '0;
      darray_wen         = '0;
      darray_wsrc        = 1'b0;
      addr_src           = 2'd0;
      dirty_set          = 1'b0;
      dirty_clr          = 1'b0;
`ifdef CACHE_FLUSH_EN
      flush_done         = 1'b0;
`endif
      case (state)
         IDLE: begin
            bus.memreq_rdy = out_en && !flush_go;
            reg_en_M0      = out_en && !flush_go && bus.memreq_val;
         end
         TAG: begin
            way_sel = hit ? hit_way : victim;
            if (hit && type_q) begin
               darray_wen = NUM_WAYS'(1) << hit_way;
               dirty_set  = 1'b1;
            end
         end
         SPILL: begin
            addr_src           = 2'd1;
            bus.cache_req_val  = 1'b1;
            bus.cache_req_type = 1'b1;
            dirty_clr          = bus.cache_req_rdy && (word_q == WORD_LAST);
         end
         REFILL: begin
            addr_src           = 2'd2;
            bus.cache_req_val  = !req_done;
            bus.cache_resp_rdy = 1'b1;
            if (bus.cache_resp_val) begin
               darray_wen  = NUM_WAYS'(1) << way_q;
               darray_wsrc = 1'b1;
               if (rword_q == WORD_LAST) tarray_wen = NUM_WAYS'(1) << way_q;
            end
         end
         RESP: bus.memresp_val = 1'b1;
`ifdef CACHE_FLUSH_EN
         FLUSH_RD: addr_src = 2'd3;
         FLUSH_CHK: begin
            addr_src   = 2'd3;
            way_sel    = dirty_found ? dirty_way : way_q;
            flush_done = !dirty_found && (set_q == SET_LAST);
         end
`endif
         default: ;
      endcase
   end

   assign word_idx      = word_q;
   assign resp_word_idx = rword_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         out_en   <= 1'b0;
         type_q   <= 1'b0;
         req_done <= 1'b0;
         way_q    <= '0;
         rr_ptr   <= '0;
         word_q   <= '0;
         rword_q  <= '0;
`ifdef CACHE_FLUSH_EN
         flushing <= 1'b0;
         set_q    <= '0;
`endif
      end else begin
         out_en <= 1'b1;
         case (state)
            IDLE: begin
`ifdef CACHE_FLUSH_EN
               if (flush_go) begin
                  flushing <= 1'b1;
                  state    <= FLUSH_RD;
               end else
`endif
               if (out_en && bus.memreq_val) begin
                  type_q <= bus.memreq_type;
                  state  <= TAG;
               end
            end
            TAG: begin
               if (hit) begin
                  way_q <= hit_way;
                  state <= RESP;
               end else begin
                  way_q <= victim;
                  state <= (line_valid_vec[victim] && line_dirty_vec[victim]) ? SPILL : REFILL;
               end
            end
            SPILL: begin
               if (bus.cache_req_rdy) begin
                  word_q <= word_q + 1'b1;
                  if (word_q == WORD_LAST) begin
`ifdef CACHE_FLUSH_EN
                     state <= flushing ? FLUSH_RD : REFILL;
`else
                     state <= REFILL;
`endif
                  end
               end
            end
            REFILL: begin
               // Requests run ahead of responses; req_done stops them once the counter wraps.
               if (!req_done && bus.cache_req_rdy) begin
                  word_q <= word_q + 1'b1;
                  if (word_q == WORD_LAST) req_done <= 1'b1;
               end
               if (bus.cache_resp_val) begin
                  rword_q <= rword_q + 1'b1;
                  if (rword_q == WORD_LAST) begin
                     req_done <= 1'b0;
                     rr_ptr   <= (rr_ptr == WAY_LAST) ? '0 : rr_ptr + 1'b1;
                     state    <= TAG;
                  end
               end
            end
            RESP: if (bus.memresp_rdy) state <= IDLE;
`ifdef CACHE_FLUSH_EN
            FLUSH_RD: state <= FLUSH_CHK;
            FLUSH_CHK: begin
               if (dirty_found) begin
                  way_q <= dirty_way;
                  state <= SPILL;
               end else if (set_q == SET_LAST) begin
                  set_q    <= '0;
                  flushing <= 1'b0;
                  state    <= IDLE;
               end else begin
                  set_q <= set_q + 1'b1;
                  state <= FLUSH_RD;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
